// File: rtl/d_write_buffer.sv
// Posted-write buffer between the data cache and the AXI bridge's sram-like port.
// Writes are acked one cycle after acceptance and drained in order; reads wait for an empty buffer.
module d_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_req,
    input  logic        in_wr,
    input  logic [1:0]  in_size,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic [31:0] in_rdata,
    output logic        in_addr_ok,
    output logic        in_data_ok,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    output logic        wb_empty
);
    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    localparam logic [0:0] D_IDLE = 1'b0;
    localparam logic [0:0] D_WAIT = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_WAIT = 1'b1;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } entry_t;

    entry_t        fifo_q [DEPTH];
    entry_t        head;
    entry_t        entry_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_ack_q, wr_ack_d;
    logic [0:0]    d_state_q, d_state_d;
    logic [0:0]    r_state_q, r_state_d;
    logic          push, pop, drain_req, rd_eligible;

    // A write is refused while a read is outstanding so the read data path stays unambiguous.
    assign push        = in_req & in_wr & (count_q != FULL_COUNT) & (r_state_q == R_IDLE);
    assign pop         = (d_state_q == D_WAIT) & mem_data_ok;
    assign drain_req   = (d_state_q == D_IDLE) & (count_q != '0);
    assign rd_eligible = (r_state_q == R_IDLE) & in_req & ~in_wr &
                         (count_q == '0) & (d_state_q == D_IDLE);
    assign head        = fifo_q[rd_ptr_q];
    assign entry_d     = '{addr: in_addr, size: in_size, wdata: in_wdata};

    always_comb begin
        mem_req    = drain_req | rd_eligible;
        mem_wr     = ~rd_eligible;
        mem_addr   = rd_eligible ? in_addr : head.addr;
        mem_size   = rd_eligible ? in_size : head.size;
        mem_wdata  = head.wdata;
        in_addr_ok = push | (rd_eligible & mem_addr_ok);
        in_data_ok = wr_ack_q | ((r_state_q == R_WAIT) & mem_data_ok);
        in_rdata   = mem_rdata;
        wb_empty   = (count_q == '0);
    end

    always_comb begin
        // NOTE: every signal gets a default before the branches, so no path leaves it unassigned and no latch is inferred.
        d_state_d = d_state_q;
        r_state_d = r_state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ack_d  = push;

        if (d_state_q == D_IDLE) begin
            if (drain_req && mem_addr_ok) d_state_d = D_WAIT;
        end else if (mem_data_ok) begin
            d_state_d = D_IDLE;
        end

        if (r_state_q == R_IDLE) begin
            if (rd_eligible && mem_addr_ok) r_state_d = R_WAIT;
        end else if (mem_data_ok) begin
            r_state_d = R_IDLE;
        end

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end

    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wr_ack_q  <= 1'b0;
            d_state_q <= D_IDLE;
            r_state_q <= R_IDLE;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wr_ack_q  <= wr_ack_d;
            d_state_q <= d_state_d;
            r_state_q <= r_state_d;
        end
    end

    // NOTE: storage is deliberately not reset; count and pointers decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= entry_d;
    end

endmodule

// File: tb/tb_d_write_buffer.sv
// Directed bench for d_write_buffer: a queue-based reference model checks every cycle,
// and literal expectations pin the documented timing scenarios.
module tb_d_write_buffer;
    localparam int DEPTH = 4;

    logic        clk;
    logic        resetn;
    logic        in_req, in_wr;
    logic [1:0]  in_size;
    logic [31:0] in_addr, in_wdata, in_rdata;
    logic        in_addr_ok, in_data_ok;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_addr_ok, mem_data_ok;
    logic        wb_empty;

    int checks = 0;
    int errors = 0;

    d_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_req     (in_req),
        .in_wr      (in_wr),
        .in_size    (in_size),
        .in_addr    (in_addr),
        .in_wdata   (in_wdata),
        .in_rdata   (in_rdata),
        .in_addr_ok (in_addr_ok),
        .in_data_ok (in_data_ok),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .mem_size   (mem_size),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok),
        .wb_empty   (wb_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pending writes as a queue, plus which memory transaction is in flight.
    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } entry_t;

    entry_t mq[$];
    bit     m_ack, m_drain, m_read;

    always @(negedge clk) begin : model
        int     n;
        bit     wr_acc, drain_req, rd_elig;
        entry_t e;
        if (!resetn) begin
            mq.delete();
            m_ack   = 1'b0;
            m_drain = 1'b0;
            m_read  = 1'b0;
            check("rst_mem_req", mem_req, 0);
            check("rst_in_addr_ok", in_addr_ok, 0);
            check("rst_in_data_ok", in_data_ok, 0);
            check("rst_wb_empty", wb_empty, 1);
        end else begin
            n         = mq.size();
            wr_acc    = in_req && in_wr && (n < DEPTH) && !m_read;
            drain_req = (n != 0) && !m_drain;
            rd_elig   = in_req && !in_wr && (n == 0) && !m_read;

            check("m_mem_req", mem_req, drain_req || rd_elig);
            check("m_in_addr_ok", in_addr_ok, wr_acc || (rd_elig && mem_addr_ok));
            check("m_in_data_ok", in_data_ok, m_ack || (m_read && mem_data_ok));
            check("m_wb_empty", wb_empty, n == 0);
            check("m_in_rdata", in_rdata, mem_rdata);
            if (drain_req) begin
                check("m_drain_wr", mem_wr, 1);
                check("m_drain_addr", mem_addr, mq[0].addr);
                check("m_drain_size", mem_size, mq[0].size);
                check("m_drain_wdata", mem_wdata, mq[0].wdata);
            end
            if (rd_elig) begin
                check("m_read_wr", mem_wr, 0);
                check("m_read_addr", mem_addr, in_addr);
                check("m_read_size", mem_size, in_size);
            end

            m_ack = wr_acc;
            if (m_drain && mem_data_ok) begin
                void'(mq.pop_front());
                m_drain = 1'b0;
            end else if (drain_req && mem_addr_ok) begin
                m_drain = 1'b1;
            end
            if (m_read && mem_data_ok)      m_read = 1'b0;
            else if (rd_elig && mem_addr_ok) m_read = 1'b1;
            if (wr_acc) begin
                e.addr  = in_addr;
                e.size  = in_size;
                e.wdata = in_wdata;
                mq.push_back(e);
            end
        end
    end

    // Write requests accepted by the memory side, in order.
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    always @(negedge clk) begin
        if (resetn && mem_req && mem_addr_ok && mem_wr) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end
    end

    task automatic idle();
        in_req      = 1'b0;
        in_wr       = 1'b0;
        in_size     = 2'd2;
        in_addr     = '0;
        in_wdata    = '0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        in_req   = 1'b1;
        in_wr    = 1'b1;
        in_size  = 2'd2;
        in_addr  = a;
        in_wdata = d;
    endtask

    task automatic rd(input logic [31:0] a);
        in_req  = 1'b1;
        in_wr   = 1'b0;
        in_size = 2'd2;
        in_addr = a;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Presents n writes (held until accepted) while a responder drains, until the buffer is empty.
    task automatic stream(input int n, input int first, input logic [31:0] base, input int budget);
        int sent = 0;
        bit outst = 1'b0;
        bit acc, hs;
        bit done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            if (sent < n) wr(base + 32'(4 * (first + sent)), 32'hA5A5_0000 + 32'(first + sent));
            else begin
                in_req = 1'b0;
                in_wr  = 1'b0;
            end
            mem_addr_ok = 1'b1;
            mem_data_ok = outst;
            @(negedge clk);
            acc  = in_req && in_addr_ok;
            hs   = mem_req && mem_addr_ok;
            done = (sent >= n) && wb_empty;
            next();
            if (acc) sent++;
            outst = hs;
        end
        idle();
        check("stream_done", done, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        resetn = 1'b0;
        @(negedge clk);
        check("reset_wb_empty", wb_empty, 1);
        check("reset_mem_req", mem_req, 0);
        next();
        resetn = 1'b1;
        next();

        // Single write, memory answers addr_ok at once and data_ok in cycle 3.
        wr(32'h1000_0004, 32'hDEAD_BEEF);
        mem_addr_ok = 1'b1;
        @(negedge clk);
        check("sw_c0_addr_ok", in_addr_ok, 1);
        next();
        in_req = 1'b0;
        @(negedge clk);
        check("sw_c1_data_ok", in_data_ok, 1);
        check("sw_c1_mem_req", mem_req, 1);
        check("sw_c1_mem_addr", mem_addr, 32'h1000_0004);
        check("sw_c1_mem_wr", mem_wr, 1);
        check("sw_c1_mem_size", mem_size, 2);
        check("sw_c1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        next();
        @(negedge clk);
        check("sw_c2_mem_req", mem_req, 0);
        next();
        mem_data_ok = 1'b1;
        @(negedge clk);
        check("sw_c3_wb_empty", wb_empty, 0);
        next();
        mem_data_ok = 1'b0;
        @(negedge clk);
        check("sw_c4_wb_empty", wb_empty, 1);
        next();
        idle();

        // Fill to full with the memory stalled; the fifth write waits for the first pop.
        log_addr.delete();
        log_data.delete();
        for (int i = 0; i < 4; i++) begin
            wr(32'h4000_0000 + 32'(4 * i), 32'hA0 + 32'(i));
            @(negedge clk);
            check("fill_accept", in_addr_ok, 1);
            if (i > 0) check("fill_ack", in_data_ok, 1);
            next();
        end
        wr(32'h4000_0010, 32'hA4);
        @(negedge clk);
        check("full_c4_addr_ok", in_addr_ok, 0);
        check("full_c4_ack", in_data_ok, 1);
        next();
        mem_addr_ok = 1'b1;
        @(negedge clk);
        check("full_c5_addr_ok", in_addr_ok, 0);
        check("full_c5_ack", in_data_ok, 0);
        check("full_c5_head", mem_addr, 32'h4000_0000);
        next();
        mem_addr_ok = 1'b0;
        @(negedge clk);
        check("full_c6_addr_ok", in_addr_ok, 0);
        next();
        mem_data_ok = 1'b1;
        @(negedge clk);
        check("full_pop_addr_ok", in_addr_ok, 0);
        next();
        mem_data_ok = 1'b0;
        @(negedge clk);
        check("full_after_pop_addr_ok", in_addr_ok, 1);
        next();
        idle();
        stream(0, 0, 32'h0, 40);
        check("fill_drained", log_addr.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < log_addr.size()) check("fill_order", log_addr[i], 32'h4000_0000 + 32'(4 * i));

        // Read after write: the read reaches memory only after the write's data_ok.
        wr(32'h2000_0000, 32'h11);
        mem_addr_ok = 1'b1;
        next();
        rd(32'h2000_0000);
        @(negedge clk);
        check("raw_c1_drain_wr", mem_wr, 1);
        next();
        @(negedge clk);
        check("raw_c2_mem_req", mem_req, 0);
        check("raw_c2_addr_ok", in_addr_ok, 0);
        next();
        mem_data_ok = 1'b1;
        @(negedge clk);
        check("raw_c3_mem_req", mem_req, 0);
        next();
        mem_data_ok = 1'b0;
        @(negedge clk);
        check("raw_c4_mem_req", mem_req, 1);
        check("raw_c4_mem_wr", mem_wr, 0);
        check("raw_c4_addr_ok", in_addr_ok, 1);
        next();
        in_req      = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h11;
        @(negedge clk);
        check("raw_c5_data_ok", in_data_ok, 1);
        check("raw_c5_rdata", in_rdata, 32'h11);
        next();
        idle();
        next();

        // Read bypass on an empty buffer; a write during the read waits until cycle 3.
        rd(32'h3000_0008);
        mem_addr_ok = 1'b1;
        @(negedge clk);
        check("byp_c0_addr_ok", in_addr_ok, 1);
        check("byp_c0_mem_addr", mem_addr, 32'h3000_0008);
        next();
        wr(32'h3000_0010, 32'h55);
        mem_addr_ok = 1'b0;
        @(negedge clk);
        check("byp_c1_addr_ok", in_addr_ok, 0);
        check("byp_c1_data_ok", in_data_ok, 0);
        next();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hCAFE_F00D;
        @(negedge clk);
        check("byp_c2_data_ok", in_data_ok, 1);
        check("byp_c2_rdata", in_rdata, 32'hCAFE_F00D);
        check("byp_c2_addr_ok", in_addr_ok, 0);
        next();
        mem_data_ok = 1'b0;
        @(negedge clk);
        check("byp_c3_wr_accept", in_addr_ok, 1);
        next();
        in_req = 1'b0;
        @(negedge clk);
        check("byp_c4_wr_ack", in_data_ok, 1);
        next();
        idle();
        stream(0, 0, 32'h0, 20);

        // Push and pop on the same edge at count 2, then six more writes so pointers wrap twice.
        log_addr.delete();
        log_data.delete();
        wr(32'h5000_0000, 32'hA5A5_0000);
        next();
        wr(32'h5000_0004, 32'hA5A5_0001);
        next();
        in_req      = 1'b0;
        mem_addr_ok = 1'b1;
        next();
        wr(32'h5000_0008, 32'hA5A5_0002);
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        @(negedge clk);
        check("pp_push_accept", in_addr_ok, 1);
        next();
        in_req      = 1'b0;
        mem_data_ok = 1'b0;
        mem_addr_ok = 1'b1;
        next();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        next();
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b0;
        next();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        @(negedge clk);
        check("pp_last_pop_not_empty", wb_empty, 0);
        next();
        mem_data_ok = 1'b0;
        @(negedge clk);
        check("pp_empty_after_two", wb_empty, 1);
        next();
        idle();
        stream(6, 3, 32'h5000_0000, 60);
        check("pp_total", log_addr.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < log_addr.size()) begin
                check("pp_addr", log_addr[i], 32'h5000_0000 + 32'(4 * i));
                check("pp_data", log_data[i], 32'hA5A5_0000 + 32'(i));
            end
        end

        // Asynchronous reset in the middle of a drain with two entries queued.
        wr(32'h6000_0000, 32'h1);
        next();
        wr(32'h6000_0004, 32'h2);
        next();
        in_req      = 1'b0;
        mem_addr_ok = 1'b1;
        next();
        mem_addr_ok = 1'b0;
        @(negedge clk);
        check("mid_wait_mem_req", mem_req, 0);
        check("mid_wait_not_empty", wb_empty, 0);
        next();
        #2;
        resetn = 1'b0;
        @(negedge clk);
        check("mid_rst_mem_req", mem_req, 0);
        check("mid_rst_wb_empty", wb_empty, 1);
        check("mid_rst_data_ok", in_data_ok, 0);
        next();
        next();
        resetn = 1'b1;
        log_addr.delete();
        mem_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_req", mem_req, 0);
            next();
        end
        check("post_rst_no_stale", log_addr.size(), 0);
        idle();
        next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/d_write_buffer.md
# d_write_buffer

Posted-write buffer between the data cache's memory-side port and the AXI bridge's sram-like data port. Writes are acknowledged to the cache one cycle after acceptance and drained to memory in order from a small FIFO. Reads bypass the FIFO but are held until it is empty, so a read never overtakes an older write. One clock; requests on both sides follow the sram-like req/addr_ok/data_ok protocol.

## Interface
- DEPTH, 4, number of write entries; power of two, at least 2.
- clk  in  1  clock.
- resetn  in  1  Asynchronous, active-low reset.
- in_req / in_wr  in  1 / 1  Request and write flag from the cache. Request is held until `in_addr_ok`.
- in_size  in  2  Size code: 0 byte, 1 half, 2 word.
- in_addr / in_wdata  in  32 / 32  Physical address and write data.
- in_rdata  out  32  Read data, valid with `in_data_ok` for reads.
- in_addr_ok / in_data_ok  out  1 / 1  Upstream handshake.
- mem_req / mem_wr  out  1 / 1  Request and write flag to the bridge.
- mem_size / mem_addr / mem_wdata  out  2 / 32 / 32  Request fields to the bridge.
- mem_rdata  in  32  Read data from the bridge.
- mem_addr_ok / mem_data_ok  in  1 / 1  Downstream handshake.
- wb_empty  out  1  High when the FIFO holds no entries and no drain is outstanding.

## Operation
- **FIFO storage.** `DEPTH` entries of {addr[31:0], size[1:0], wdata[31:0]}.
  - Write and read pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
  - `count` is 0..DEPTH, log2(DEPTH)+1 bits wide.
- **Write accept.** `in_addr_ok = 1` when `in_req & in_wr & count != DEPTH`. The entry is pushed on that edge.
- **Write acknowledge.** A registered `wr_ack` pulse drives `in_data_ok` in the following cycle.
- **Drain FSM, states D_IDLE and D_WAIT.**
  - D_IDLE: `mem_req = (count != 0)`, with `mem_wr = 1` and the head entry's fields. On `mem_addr_ok`, go to D_WAIT.
  - D_WAIT: `mem_req = 0`. On `mem_data_ok`, pop the head and go to D_IDLE.
- **Read FSM, states R_IDLE and R_WAIT.**
  - R_IDLE: a read is eligible when `in_req & ~in_wr & count == 0 & d_state == D_IDLE`.
  - While eligible, `mem_req = 1`, `mem_wr = 0`, and mem_size/mem_addr are taken from the in_* inputs.
  - While eligible, `in_addr_ok = mem_addr_ok`. On that handshake, go to R_WAIT.
  - R_WAIT: `in_rdata = mem_rdata` and `in_data_ok = mem_data_ok`. On `mem_data_ok`, go to R_IDLE.
- **Arbitration.** Drains and reads are mutually exclusive, and the drain always wins.
  - A read waits for `count == 0`, which implies D_IDLE.
  - Writes are not accepted while `r_state == R_WAIT`.
- **Output composition.**
  - `in_data_ok = wr_ack | (r_state == R_WAIT & mem_data_ok)`.
  - `in_rdata = mem_rdata` at all times.
- **Simultaneous push and pop.** `count` is unchanged and both pointers advance.
- **Full FIFO.** A write request waits with `in_addr_ok = 0` until a pop. The pop frees the slot on that edge, so acceptance is possible in the next cycle.
- **Empty FIFO.** `mem_req` is driven by a read only, or is 0.
- **No forwarding.** Reads never hit in the buffer. Ordering is the only correctness mechanism.
- **Reset.** An asynchronous assertion clears pointers, count, `wr_ack` and both FSMs immediately, including mid-transaction. Any outstanding bridge transaction is abandoned, because the bridge shares the reset.
- **Reset values.** `mem_req = 0`, `in_addr_ok = 0` (no request present), `in_data_ok = 0`, `wb_empty = 1`. Remaining mem_* outputs show entry 0 or the in_* pass-through and are don't-care.

## Timing
- **Write latency.**
  - Accepted at cycle N, `in_data_ok` at N+1.
  - Earliest `mem_req` for that entry at N+1.
  - The pop occurs on the edge of the `mem_data_ok` cycle.
- **Back-to-back writes.** One write per cycle until full.
- **Read with empty FIFO.** `in_addr_ok` is combinational with `mem_addr_ok`, and `in_data_ok` is combinational with `mem_data_ok`. The buffer adds 0 cycles.
- **Read after write.** The read request is first presented to memory in the cycle after the last drain's `mem_data_ok`.
- **Handshake rules.** `mem_req` is held with stable fields until `mem_addr_ok`. At most one memory transaction is outstanding.
- **`wb_empty`.** Equals `count == 0`, combinational.

## Test plan
- **Reset.** Assert `resetn = 0` mid-drain, with count = 2 and D_WAIT.
  - During reset: `mem_req = 0`, `wb_empty = 1`, `in_data_ok = 0`.
  - After release: no stale write is issued.
- **Single write.** Write sw 0x1000_0004 = 0xDEADBEEF at cycle 0 with `mem_addr_ok` tied to 1 and `mem_data_ok` 3 cycles later.
  - `in_data_ok` at cycle 1.
  - `mem_req` at cycle 1 with addr 0x1000_0004, wr = 1, size = 2.
  - `wb_empty` at cycle 4.
- **Fill to full.** Issue 5 consecutive writes with DEPTH = 4 and `mem_addr_ok` held at 0.
  - The 4 writes are acked.
  - The 5th write sees `in_addr_ok = 0` until the first pop, then is accepted next cycle.
  - Memory receives the 5 writes in address order.
- **Read-after-write ordering.** Write 0x2000_0000 = 0x11, then read 0x2000_0000.
  - The read `mem_req` appears only after the write's `mem_data_ok`.
  - `in_rdata = mem_rdata`, returned by the bench as 0x11, with `in_data_ok` in the same cycle.
- **Read bypass on empty FIFO.** Read 0x3000_0008 with an immediate `mem_addr_ok` and `mem_data_ok` 2 cycles later.
  - `in_addr_ok` at cycle 0, `in_data_ok` at cycle 2.
  - A write presented during R_WAIT is stalled until cycle 3.
- **Push and pop in the same cycle.** Start at count = 2, then push and pop in the same cycle.
  - count stays 2.
  - Pointers wrap correctly across DEPTH, checked after 9 writes.
